// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the miniTB master and slave.
// Holds the HTRANS encodings and the width-independent data-phase slot.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  // Only the direction is needed once a transfer has left its address phase.
  typedef struct packed {
    logic valid;
    logic write;
  } data_slot_t;

endpackage

// File: rtl/ahb_master.sv
// Single-initiator AHB-Lite master: turns a valid/ready command stream into
// pipelined NONSEQ transfers and returns one in-order response per command.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 hselx,
  output logic [addrWidth-1:0] haddr,
  output logic                 hwrite,
  output logic [1:0]           htrans,
  output logic [dataWidth-1:0] hwdata,
  input  logic                 hready,
  input  logic [dataWidth-1:0] hrdata
);

  // The address-phase slot doubles as the address-phase bus register, so
  // haddr/hwrite naturally hold their last values while the slot is empty.
  typedef struct packed {
    logic                 valid;
    logic                 write;
    logic [addrWidth-1:0] addr;
    logic [dataWidth-1:0] wdata;
  } addr_slot_t;

  addr_slot_t             r_aslot;
  data_slot_t             r_dslot;
  logic [dataWidth-1:0]   r_hwdata;
  logic                   r_rsp_valid;
  logic                   r_rsp_write;
  logic [dataWidth-1:0]   r_rsp_rdata;
  logic                   w_accept;

  // No command buffer: acceptance is exactly the pipeline advancing.
  assign cmd_ready = !hreset && hready;
  assign w_accept  = cmd_valid && cmd_ready;

  assign hselx     = r_aslot.valid;
  assign htrans    = r_aslot.valid ? NONSEQ : IDLE;
  assign haddr     = r_aslot.addr;
  assign hwrite    = r_aslot.write;
  assign hwdata    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;

  // NOTE: non-blocking assignments let the data slot take the old address
  // slot on the same edge the address slot takes the new command.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_aslot     <= '0;
      r_dslot     <= '0;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (hready) begin
        if (r_dslot.valid) begin
          r_rsp_valid <= 1'b1;
          r_rsp_write <= r_dslot.write;
          r_rsp_rdata <= r_dslot.write ? '0 : hrdata;
        end
        r_dslot.valid <= r_aslot.valid;
        r_dslot.write <= r_aslot.write;
        if (r_aslot.valid && r_aslot.write) begin
          r_hwdata <= r_aslot.wdata;
        end
        if (w_accept) begin
          r_aslot.valid <= 1'b1;
          r_aslot.write <= cmd_write;
          r_aslot.addr  <= cmd_addr;
          r_aslot.wdata <= cmd_wdata;
        end else begin
          r_aslot.valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: a behavioural AHB-Lite slave with
// controllable hready, plus an in-order response scoreboard.
module tb_ahb_master;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        hselx;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;

  always #5 hclk = ~hclk;

  ahb_master #(.addrWidth(8), .dataWidth(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .hselx(hselx), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hwdata(hwdata), .hready(hready), .hrdata(hrdata)
  );

  // Behavioural slave: memory, data-phase register, garbage on hrdata while stalled
  logic [31:0] mem [256];
  logic        sd_valid;
  logic        sd_write;
  logic [7:0]  sd_addr;

  always @(posedge hclk) begin
    if (hreset) begin
      sd_valid <= 1'b0;
      sd_write <= 1'b0;
      sd_addr  <= 8'h00;
    end else if (hready) begin
      if (sd_valid && sd_write) mem[sd_addr] <= hwdata;
      sd_valid <= hselx && (htrans == 2'b10);
      sd_write <= hwrite;
      sd_addr  <= haddr;
    end
  end

  assign hrdata = !hready ? 32'hBAD0_BAD0 :
                  (sd_valid && !sd_write) ? mem[sd_addr] : 32'h0;

  // Scoreboard and counters
  typedef struct {
    logic        write;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rsp_cnt = 0;
  int   last_rsp_cyc = 0;
  int   prev_rsp_cyc = 0;
  int   run     = 0;
  int   max_run = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  always @(negedge hclk) begin
    if (htrans == 2'b10) run = run + 1;
    else run = 0;
    if (run > max_run) max_run = run;
    if (rsp_valid === 1'b1) begin
      exp_t e;
      rsp_cnt      = rsp_cnt + 1;
      prev_rsp_cyc = last_rsp_cyc;
      last_rsp_cyc = cyc;
      n_tests = n_tests + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL rsp_unexpected: got write=%0b rdata=%h, required no response", rsp_write, rsp_rdata);
      end else begin
        e = sb.pop_front();
        if (rsp_write !== e.write || rsp_rdata !== e.rdata) begin
          n_fail = n_fail + 1;
          $display("FAIL rsp_data: got write=%0b rdata=%h, required write=%0b rdata=%h",
                   rsp_write, rsp_rdata, e.write, e.rdata);
        end
      end
    end
  end

  // Offer one command and wait (bounded) for the accepting edge; returns at edge+1.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd);
    int waited = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    do begin
      @(posedge hclk);
      waited++;
    end while (!cmd_ready && waited < 50);
    n_tests = n_tests + 1;
    if (cmd_ready) begin
      e.write = w;
      e.rdata = w ? 32'h0 : exp_rd;
      sb.push_back(e);
    end else begin
      n_fail = n_fail + 1;
      $display("FAIL accept_timeout: addr=%h not accepted after %0d cycles, required acceptance", a, waited);
    end
    #1;
  endtask

  task automatic drain();
    int waited = 0;
    cmd_valid = 1'b0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge hclk);
      waited++;
    end
    repeat (2) @(negedge hclk);
    n_tests = n_tests + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic release_reset();
    @(posedge hclk); #1;
    hreset = 1'b0;
    hready = 1'b0;
    @(posedge hclk); #1;
    hready = 1'b1;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hready = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    n_tests = n_tests + 1;
    if ({htrans, hselx, haddr, hwrite, hwdata} !== 44'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_bus: htrans=%b hselx=%b haddr=%h hwrite=%b hwdata=%h, required all 0",
               htrans, hselx, haddr, hwrite, hwdata);
    end
    n_tests = n_tests + 1;
    if ({rsp_valid, rsp_write, rsp_rdata} !== 34'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_rsp: valid=%b write=%b rdata=%h, required all 0", rsp_valid, rsp_write, rsp_rdata);
    end
    hready = 1'b1;
    #1;
    n_tests = n_tests + 1;
    if (cmd_ready !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready);
    end
    release_reset();
  endtask

  task automatic test_single_write();
    issue(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0);
    cmd_valid = 1'b0;
    @(negedge hclk);
    n_tests = n_tests + 1;
    if (htrans !== 2'b10 || hselx !== 1'b1 || haddr !== 8'h10 || hwrite !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL wr_addr_phase: htrans=%b hselx=%b haddr=%h hwrite=%b, required 10 1 10 1",
               htrans, hselx, haddr, hwrite);
    end
    @(negedge hclk);
    n_tests = n_tests + 1;
    if (hwdata !== 32'hDEAD_BEEF || htrans !== 2'b00 || hselx !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL wr_data_phase: hwdata=%h htrans=%b hselx=%b rsp_valid=%b, required deadbeef 00 0 0",
               hwdata, htrans, hselx, rsp_valid);
    end
    @(negedge hclk);
    n_tests = n_tests + 1;
    if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL wr_rsp_timing: valid=%b write=%b rdata=%h, required 1 1 0", rsp_valid, rsp_write, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_write_read();
    issue(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0);
    issue(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF);
    drain();
    n_tests = n_tests + 1;
    if (last_rsp_cyc - prev_rsp_cyc != 1) begin
      n_fail = n_fail + 1;
      $display("FAIL wr_rd_spacing: got %0d cycles between responses, required 1", last_rsp_cyc - prev_rsp_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    logic [7:0] a;
    start_cnt = rsp_cnt;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      a = 8'(i);
      issue(1'b1, a, 32'h100 + 32'(i), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      a = 8'(i);
      issue(1'b0, a, 32'h0, 32'h100 + 32'(i));
    end
    drain();
    n_tests = n_tests + 1;
    if (max_run != 16) begin
      n_fail = n_fail + 1;
      $display("FAIL b2b_nonseq_run: got %0d consecutive NONSEQ cycles, required 16", max_run);
    end
    n_tests = n_tests + 1;
    if (rsp_cnt - start_cnt != 16) begin
      n_fail = n_fail + 1;
      $display("FAIL b2b_rsp_count: got %0d responses, required 16", rsp_cnt - start_cnt);
    end
  endtask

  task automatic test_wait_states();
    logic [1:0]  s_htrans;
    logic [7:0]  s_haddr;
    logic [31:0] s_hwdata;
    int          start_cnt;
    issue(1'b1, 8'h20, 32'h1234_5678, 32'h0);
    drain();
    start_cnt = rsp_cnt;
    issue(1'b0, 8'h20, 32'h0, 32'h1234_5678);
    cmd_valid = 1'b0;
    @(posedge hclk); #1;
    hready    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h21;
    cmd_wdata = 32'hCAFE_0001;
    @(negedge hclk);
    s_htrans = htrans; s_haddr = haddr; s_hwdata = hwdata;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      n_tests = n_tests + 1;
      if (htrans !== s_htrans || haddr !== s_haddr || hwdata !== s_hwdata ||
          cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL wait_frozen[%0d]: htrans=%b haddr=%h hwdata=%h cmd_ready=%b rsp_valid=%b, required %b %h %h 0 0",
                 i, htrans, haddr, hwdata, cmd_ready, rsp_valid, s_htrans, s_haddr, s_hwdata);
      end
    end
    hready = 1'b1;
    @(posedge hclk);
    n_tests = n_tests + 1;
    if (cmd_ready === 1'b1) begin
      exp_t e;
      e.write = 1'b1;
      e.rdata = 32'h0;
      sb.push_back(e);
    end else begin
      n_fail = n_fail + 1;
      $display("FAIL wait_resume_accept: cmd_ready=%b, required 1", cmd_ready);
    end
    #1;
    drain();
    n_tests = n_tests + 1;
    if (rsp_cnt - start_cnt != 2) begin
      n_fail = n_fail + 1;
      $display("FAIL wait_rsp_count: got %0d responses, required 2", rsp_cnt - start_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int start_cnt;
    issue(1'b1, 8'h30, 32'h0BAD_F00D, 32'h0);
    issue(1'b0, 8'h31, 32'h0, 32'h0);
    cmd_valid = 1'b0;
    hreset    = 1'b1;
    sb.delete();
    start_cnt = rsp_cnt;
    @(negedge hclk);
    n_tests = n_tests + 1;
    if (cmd_ready !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_reset_cmd_ready: got %b, required 0", cmd_ready);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    hready = 1'b0;
    @(negedge hclk);
    n_tests = n_tests + 1;
    if (htrans !== 2'b00 || hselx !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_reset_idle: htrans=%b hselx=%b rsp_valid=%b, required 00 0 0", htrans, hselx, rsp_valid);
    end
    @(posedge hclk); #1;
    hready = 1'b1;
    repeat (4) @(negedge hclk);
    n_tests = n_tests + 1;
    if (rsp_cnt != start_cnt) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_reset_dropped: got %0d responses, required 0", rsp_cnt - start_cnt);
    end
    issue(1'b1, 8'h05, 32'hA5A5_A5A5, 32'h0);
    issue(1'b0, 8'h05, 32'h0, 32'hA5A5_A5A5);
    drain();
    n_tests = n_tests + 1;
    if (rsp_cnt - start_cnt != 2) begin
      n_fail = n_fail + 1;
      $display("FAIL post_reset_rsp_count: got %0d responses, required 2", rsp_cnt - start_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
